// File: rtl/pmp_check_arbiter.sv
// Round-robin arbiter sharing one combinational PMP checker between the AR and AW paths.
// Each check takes three cycles: request handshake, one checker cycle, then the response.
module pmp_check_arbiter #(
  parameter int unsigned PLEN  = 34,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rd_req_valid_i,
  output logic             rd_req_ready_o,
  input  logic [PLEN-1:0]  rd_addr_i,
  input  logic [1:0]       rd_priv_lvl_i,
  output logic             rd_resp_valid_o,
  input  logic             rd_resp_ready_i,
  output logic             rd_allow_o,
  input  logic             wr_req_valid_i,
  output logic             wr_req_ready_o,
  input  logic [PLEN-1:0]  wr_addr_i,
  input  logic [1:0]       wr_priv_lvl_i,
  output logic             wr_resp_valid_o,
  input  logic             wr_resp_ready_i,
  output logic             wr_allow_o,
  output logic [PLEN-1:0]  pmp_addr_o,
  output logic [2:0]       pmp_access_type_o,
  output logic [1:0]       pmp_priv_lvl_o,
  input  logic             pmp_allow_i,
  output logic [CNT_W-1:0] deny_cnt_o,
  output logic             busy_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  localparam logic OWN_RD = 1'b0;
  localparam logic OWN_WR = 1'b1;

  localparam logic [2:0] ACCESS_READ  = 3'b001;
  localparam logic [2:0] ACCESS_WRITE = 3'b010;

  logic [1:0]       state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [PLEN-1:0]  addr_q, addr_d;
  logic [1:0]       priv_q, priv_d;
  logic             allow_q, allow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_gnt, wr_gnt;

  always_comb begin
    state_d           = state_q;
    owner_d           = owner_q;
    last_d            = last_q;
    addr_d            = addr_q;
    priv_d            = priv_q;
    allow_d           = allow_q;
    cnt_d             = cnt_q;
    rd_gnt            = 1'b0;
    wr_gnt            = 1'b0;
    rd_resp_valid_o   = 1'b0;
    wr_resp_valid_o   = 1'b0;
    rd_allow_o        = 1'b0;
    wr_allow_o        = 1'b0;
    pmp_addr_o        = '0;
    pmp_access_type_o = '0;
    pmp_priv_lvl_o    = '0;

    case (state_q)
      IDLE: begin
        // On a tie the channel that did not win last time is granted.
        rd_gnt = rd_req_valid_i & (~wr_req_valid_i | (last_q == OWN_WR));
        wr_gnt = wr_req_valid_i & (~rd_req_valid_i | (last_q == OWN_RD));
        if (rd_gnt) begin
          owner_d = OWN_RD;
          last_d  = OWN_RD;
          addr_d  = rd_addr_i;
          priv_d  = rd_priv_lvl_i;
          state_d = CHECK;
        end else if (wr_gnt) begin
          owner_d = OWN_WR;
          last_d  = OWN_WR;
          addr_d  = wr_addr_i;
          priv_d  = wr_priv_lvl_i;
          state_d = CHECK;
        end
      end
      CHECK: begin
        pmp_addr_o        = addr_q;
        pmp_priv_lvl_o    = priv_q;
        pmp_access_type_o = (owner_q == OWN_WR) ? ACCESS_WRITE : ACCESS_READ;
        allow_d           = pmp_allow_i;
        if (!pmp_allow_i && (cnt_q != '1)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        state_d = RESP;
      end
      RESP: begin
        if (owner_q == OWN_WR) begin
          wr_resp_valid_o = 1'b1;
          wr_allow_o      = allow_q;
          if (wr_resp_ready_i) state_d = IDLE;
        end else begin
          rd_resp_valid_o = 1'b1;
          rd_allow_o      = allow_q;
          if (rd_resp_ready_i) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Readies are masked while reset is held so every output reads 0 in reset.
  assign rd_req_ready_o = rd_gnt & rst_ni;
  assign wr_req_ready_o = wr_gnt & rst_ni;
  assign deny_cnt_o     = cnt_q;
  assign busy_o         = (state_q != IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= OWN_RD;
      last_q  <= OWN_WR;
      addr_q  <= '0;
      priv_q  <= '0;
      allow_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      priv_q  <= priv_d;
      allow_q <= allow_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/pmp_check_arbiter.md
Name: pmp_check_arbiter

Overview:
- Shares one combinational PMP checker between the AXI read-address (AR) and write-address (AW) paths of the IO-PMP.
- Accepts a check request from either channel with round-robin arbitration and registers the address and privilege level.
- Drives the checker for one cycle, captures its allow result and returns it to the requesting channel over a valid/ready response handshake.
- Keeps a saturating count of denied accesses for debug/status.

Parameters:
- PLEN, 34, physical address width (rv64: 56).
- CNT_W, 16, width of denial counter.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- rd_req_valid_i  input  1  AR-path check request valid
- rd_req_ready_o  output  1  AR-path request accepted
- rd_addr_i  input  PLEN  AR address
- rd_priv_lvl_i  input  riscv::priv_lvl_t  AR privilege level
- rd_resp_valid_o  output  1  AR result valid
- rd_resp_ready_i  input  1  AR result consumed
- rd_allow_o  output  1  AR access allowed
- wr_req_valid_i  input  1  AW-path check request valid
- wr_req_ready_o  output  1  AW-path request accepted
- wr_addr_i  input  PLEN  AW address
- wr_priv_lvl_i  input  riscv::priv_lvl_t  AW privilege level
- wr_resp_valid_o  output  1  AW result valid
- wr_resp_ready_i  input  1  AW result consumed
- wr_allow_o  output  1  AW access allowed
- pmp_addr_o  output  PLEN  address to shared PMP checker
- pmp_access_type_o  output  riscv::pmp_access_t  access type to checker
- pmp_priv_lvl_o  output  riscv::priv_lvl_t  privilege to checker
- pmp_allow_i  input  1  combinational checker result
- deny_cnt_o  output  CNT_W  saturating count of denied checks
- busy_o  output  1  FSM not in IDLE

Behaviour:
- Reset: all outputs 0. FSM=IDLE, last_grant=WR (so RD wins the first tie), deny_cnt=0. Registers clear asynchronously on rst_ni low.
- FSM states: IDLE, CHECK, RESP.
- IDLE:
  - Ready is combinational from valid. Only one ready may be high per cycle.
  - Only RD valid: rd_req_ready_o=1. Only WR valid: wr_req_ready_o=1.
  - Both valid: grant the channel other than last_grant.
  - On handshake: latch addr, priv and owner (RD/WR); update last_grant=owner; go to CHECK.
  - No valid: stay in IDLE.
- CHECK (exactly 1 cycle):
  - pmp_addr_o and pmp_priv_lvl_o come from the latched registers.
  - pmp_access_type_o = ACCESS_READ (3'b001) for RD, ACCESS_WRITE (3'b010) for WR.
  - Sample pmp_allow_i into allow_q at the clock edge; go to RESP.
  - If pmp_allow_i=0, increment deny_cnt, saturating at all-ones.
- pmp_* outputs are 0 in every state other than CHECK.
- RESP:
  - The owner's resp_valid_o=1 and its allow_o=allow_q. The other channel's resp_valid_o=0 and allow_o=0.
  - Hold the response stable until the owner's resp_ready_i=1, then go to IDLE.
  - No new request is accepted during CHECK or RESP: both req_ready_o=0.
- Latency: request handshake at cycle N, response valid at N+2. With resp_ready held high, the next request can be accepted at N+3. Throughput is 1 check per 3 cycles.
- allow_o is meaningful only while resp_valid_o=1.
- busy_o=1 in CHECK and RESP.
- Fairness: with both channels continuously valid, grants strictly alternate.
- Reset mid-operation: return to IDLE immediately. Any pending response is dropped, resp_valid_o=0 and deny_cnt=0.
- Requester contract: a requester must not drop valid or change addr/priv while valid=1 and ready=0. The block never depends on this for correctness, because it samples only on handshake.

Test Plan:
- Single RD: rd_req_valid_i=1, addr=0x8000_0000, priv=U, pmp_allow_i=1 during CHECK -> rd_req_ready_o=1 at cycle 0; pmp_access_type_o=3'b001 and pmp_addr_o=0x8000_0000 at cycle 1; rd_resp_valid_o=1, rd_allow_o=1 at cycle 2; wr_resp_valid_o stays 0.
- Simultaneous RD+WR after reset, both held valid, resp_ready=1 -> grant order RD, WR, RD, WR. pmp_access_type_o alternates 001/010. Grants fall at cycles 0, 3, 6, 9.
- Deny path: WR request with pmp_allow_i=0 -> wr_allow_o=0 with wr_resp_valid_o=1; deny_cnt_o goes 0->1 in the cycle after CHECK.
- Backpressure: rd_resp_ready_i=0 for 5 cycles in RESP -> rd_resp_valid_o and rd_allow_o stay stable; both req_ready_o=0 while wr_req_valid_i=1; WR is granted in the cycle after rd_resp_ready_i=1.
- Saturation: CNT_W=2, 5 consecutive denied checks -> deny_cnt_o reads 1, 2, 3, 3, 3.
- Reset in RESP: assert rst_ni=0 while rd_resp_valid_o=1 -> rd_resp_valid_o=0 and busy_o=0 asynchronously; after release, a WR-only request is granted immediately.
